sct_update: RTL and testbench

SCT_UPDATE -- requirements
Module: sct_update

---
 rtl/sct_update.sv | 84 ++++++++
 tb/tb_sct_update.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sct_update.sv
// rtl/sct_update.sv - serial sequence-control-tank update: bit-serial increment or serial jump load
// Ten-bit SCT register that is updated one bit per clock, LSB first.
module sct_update (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_start,
   input  logic       stop_one_b,
   input  logic       ep5,
   input  logic       ot_bit,
   output logic [9:0] sct_addr,
   output logic       sct_busy,
   output logic       sct_done,
   output logic       sct_wrap,
   output logic       sct_err
);

   typedef enum logic [1:0] {IDLE, INC, LOAD, FIN} state_t;

   state_t     state, state_nx;
   logic [3:0] bit_cnt;
   logic       carry;
   logic       wrap_q;
   logic       last_bit;

   assign last_bit = (bit_cnt == 4'd9);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ep5 outranks inc_start; a suppressed increment goes straight to FIN
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (ep5)                           state_nx = LOAD;
            else if (inc_start && !stop_one_b) state_nx = INC;
            else if (inc_start)                state_nx = FIN;
         end
         INC:  if (last_bit) state_nx = FIN;
         LOAD: if (last_bit) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sct_addr <= 10'd0;
         bit_cnt  <= 4'd0;
         carry    <= 1'b0;
         wrap_q   <= 1'b0;
         sct_err  <= 1'b0;
      end else begin
         if ((inc_start || ep5) && state != IDLE) sct_err <= 1'b1;
         case (state)
            IDLE: begin
               bit_cnt <= 4'd0;
               carry   <= 1'b1;
               wrap_q  <= 1'b0;
            end
            INC: begin
               sct_addr[bit_cnt] <= sct_addr[bit_cnt] ^ carry;
               carry             <= sct_addr[bit_cnt] & carry;
               bit_cnt           <= bit_cnt + 4'd1;
               // carry out of the MSB means 1023 rolled over to 0
               if (last_bit) wrap_q <= sct_addr[bit_cnt] & carry;
            end
            LOAD: begin
               sct_addr[bit_cnt] <= ot_bit;
               bit_cnt           <= bit_cnt + 4'd1;
            end
            FIN: bit_cnt <= 4'd0;
            default: bit_cnt <= 4'd0;
         endcase
      end
   end

   assign sct_busy = (state == INC) || (state == LOAD);
   assign sct_done = (state == FIN);
   assign sct_wrap = (state == FIN) && wrap_q;

endmodule

// File: tb/tb_sct_update.sv
// tb/tb_sct_update.sv - directed scoreboard bench for sct_update
module tb_sct_update;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inc_start = 1'b0;
   logic       stop_one_b = 1'b0;
   logic       ep5 = 1'b0;
   logic       ot_bit = 1'b0;
   logic [9:0] sct_addr;
   logic       sct_busy, sct_done, sct_wrap, sct_err;

   sct_update dut (
      .clk(clk), .rst(rst), .inc_start(inc_start), .stop_one_b(stop_one_b),
      .ep5(ep5), .ot_bit(ot_bit), .sct_addr(sct_addr), .sct_busy(sct_busy),
      .sct_done(sct_done), .sct_wrap(sct_wrap), .sct_err(sct_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] addr;
      logic       wrap;
      int         lat;
      int         busy;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_err = 0;
   logic [9:0] model_addr = 10'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ld/inc select the start pulses; inject_at >= 0 re-pulses inc_start in that busy cycle
   task automatic do_op(input string tag, input bit ld, input bit inc, input bit stop,
                        input logic [9:0] data, input int inject_at);
      exp_t e;
      int   n, busy, k;
      if (ld) begin
         e.addr = data; e.wrap = 1'b0; e.lat = 11; e.busy = 10;
      end else if (stop) begin
         e.addr = model_addr; e.wrap = 1'b0; e.lat = 1; e.busy = 0;
      end else begin
         e.addr = model_addr + 10'd1; e.wrap = (model_addr == 10'h3FF);
         e.lat = 11; e.busy = 10;
      end
      model_addr = e.addr;
      sb.push_back(e);

      ep5 = ld; inc_start = inc; stop_one_b = stop;
      tick();
      ep5 = 1'b0; inc_start = 1'b0;
      stop_one_b = 1'($urandom_range(0, 1));
      n = 1; busy = 0; k = 0;
      while (sct_done !== 1'b1 && n < 30) begin
         if (sct_busy === 1'b1) begin
            if (ld) ot_bit = data[k];
            inc_start = (busy == inject_at);
            busy++; k++;
         end
         tick();
         inc_start = 1'b0;
         n++;
      end
      ot_bit = 1'b0;
      e = sb.pop_front();
      chk({tag, "_done"}, 32'(sct_done), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(busy), 32'(e.busy));
      chk({tag, "_addr"}, 32'(sct_addr), 32'(e.addr));
      chk({tag, "_wrap"}, 32'(sct_wrap), 32'(e.wrap));
      tick();
      chk({tag, "_done_pulse"}, 32'(sct_done), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_addr", 32'(sct_addr), 32'd0);
      chk("rst_busy", 32'(sct_busy), 32'd0);
      chk("rst_done", 32'(sct_done), 32'd0);
      chk("rst_wrap", 32'(sct_wrap), 32'd0);
      chk("rst_err", 32'(sct_err), 32'd0);

      do_op("inc0", 1'b0, 1'b1, 1'b0, 10'd0, -1);
      do_op("load3ff", 1'b1, 1'b0, 1'b0, 10'h3FF, -1);
      do_op("inc_wrap", 1'b0, 1'b1, 1'b0, 10'd0, -1);
      do_op("load5", 1'b1, 1'b0, 1'b0, 10'd5, -1);
      do_op("inc_supp", 1'b0, 1'b1, 1'b1, 10'd0, -1);
      do_op("load2ab", 1'b1, 1'b0, 1'b0, 10'h2AB, -1);
      do_op("ep5_and_inc", 1'b1, 1'b1, 1'b0, 10'h155, -1);
      chk("ep5_and_inc_err", 32'(sct_err), 32'd0);
      for (int i = 0; i < 3; i++) begin
         do_op("load_rand", 1'b1, 1'b0, 1'b0, 10'($urandom_range(0, 1023)), -1);
         do_op("inc_rand", 1'b0, 1'b1, 1'b0, 10'd0, -1);
      end

      do_op("inc_inject", 1'b0, 1'b1, 1'b0, 10'd0, 3);
      chk("inc_inject_err", 32'(sct_err), 32'd1);

      ep5 = 1'b1;
      tick();
      ep5 = 1'b0; ot_bit = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; ot_bit = 1'b0;
      model_addr = 10'd0;
      chk("midload_rst_addr", 32'(sct_addr), 32'd0);
      chk("midload_rst_busy", 32'(sct_busy), 32'd0);
      chk("midload_rst_done", 32'(sct_done), 32'd0);
      chk("midload_rst_wrap", 32'(sct_wrap), 32'd0);
      chk("midload_rst_err", 32'(sct_err), 32'd0);
      tick();
      chk("midload_rst_idle", 32'(sct_busy | sct_done), 32'd0);

      rst = 1'b1; inc_start = 1'b1; ep5 = 1'b1;
      tick();
      rst = 1'b0; inc_start = 1'b0; ep5 = 1'b0;
      tick();
      chk("rst_start_ignored_busy", 32'(sct_busy), 32'd0);
      chk("rst_start_ignored_done", 32'(sct_done), 32'd0);
      do_op("inc_after_rst", 1'b0, 1'b1, 1'b0, 10'd0, -1);
      chk("final_err", 32'(sct_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
